// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared constants and types for the multi-channel clock divider.
// Revision    : 1.0
// ============================================================================
package clkdiv_pkg;

    localparam int          C_CNT_W    = 32;
    localparam int unsigned C_DEF_HALF = 500_000;

    // Half-period value at the default counter width
    typedef logic [C_CNT_W-1:0] half_t;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/clkdiv_chan.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_chan
// Description : One divider channel: shadow/active half-period, counter,
//               50% duty divided clock and registered rising-edge strobe.
// Revision    : 1.0
// ============================================================================
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int          CNT_W    = C_CNT_W,
    parameter int unsigned DEF_HALF = C_DEF_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr_sel,
    input  logic [CNT_W-1:0] i_wr_half,
    output logic             o_divclk,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] C_DEF = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_divclk;
    logic             r_tick;
    logic [CNT_W-1:0] w_half_m1;
    logic             w_term;

    // A programmed half-period of zero counts as one
    assign w_half_m1 = (r_active == '0) ? '0 : (r_active - CNT_W'(1));
    assign w_term    = (r_cnt == w_half_m1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= C_DEF;
            r_active <= C_DEF;
            r_cnt    <= '0;
            r_divclk <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            if (i_wr_sel) begin
                r_shadow <= i_wr_half;
            end

            // Active always takes the pre-write shadow, so a write landing on
            // a toggle only applies from the following toggle.
            if (!i_en || i_sync) begin
                r_cnt    <= '0;
                r_divclk <= 1'b0;
                r_tick   <= 1'b0;
                r_active <= r_shadow;
            end else if (w_term) begin
                r_cnt    <= '0;
                r_divclk <= ~r_divclk;
                r_tick   <= ~r_divclk;
                r_active <= r_shadow;
            end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_tick   <= 1'b0;
            end
        end
    end

    assign o_divclk = r_divclk;
    assign o_tick   = r_tick;

endmodule : clkdiv_chan
`default_nettype wire

// File: rtl/multi_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : multi_clkdiv
// Description : N independent programmable clock dividers with per-channel
//               enable, common phase sync and a shared divisor write port.
// Revision    : 1.0
// ============================================================================
module multi_clkdiv
    import clkdiv_pkg::*;
#(
    parameter  int          N_CH     = 4,
    parameter  int          CNT_W    = C_CNT_W,
    parameter  int unsigned DEF_HALF = C_DEF_HALF,
    localparam int          CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_half,
    output logic [N_CH-1:0]  divclk,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] w_wr_sel;

    // Channel indices at or above N_CH match no decode and are dropped
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        assign w_wr_sel[gi] = wr_en && (wr_ch == CH_W'(gi));

        clkdiv_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (en[gi]),
            .i_sync    (sync),
            .i_wr_sel  (w_wr_sel[gi]),
            .i_wr_half (wr_half),
            .o_divclk  (divclk[gi]),
            .o_tick    (tick[gi])
        );
    end : g_chan

endmodule : multi_clkdiv
`default_nettype wire

// File: tb/tb_multi_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_clkdiv
// Description : Directed self-checking bench for multi_clkdiv.
// Revision    : 1.0
// ============================================================================
module tb_multi_clkdiv;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_half;
    logic [3:0]  divclk;
    logic [3:0]  tick;

    // Three-channel instance: wr_ch = 3 is representable but out of range
    logic [2:0]  en3;
    logic        sync3;
    logic        wr_en3;
    logic [1:0]  wr_ch3;
    logic [31:0] wr_half3;
    logic [2:0]  divclk3;
    logic [2:0]  tick3;

    int checks = 0;
    int errors = 0;

    multi_clkdiv #(.N_CH(4), .CNT_W(32), .DEF_HALF(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_half (wr_half),
        .divclk  (divclk),
        .tick    (tick)
    );

    multi_clkdiv #(.N_CH(3), .CNT_W(32), .DEF_HALF(2)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en3),
        .sync    (sync3),
        .wr_en   (wr_en3),
        .wr_ch   (wr_ch3),
        .wr_half (wr_half3),
        .divclk  (divclk3),
        .tick    (tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc,
                         input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Spread a per-cycle bit stream of one channel into 4-bit lanes
    function automatic logic [63:0] lane(input logic [15:0] b, input int ch);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i+ch] = b[i];
        return r;
    endfunction

    task automatic run(input string tag, input int n, input logic [63:0] dv,
                       input logic [63:0] tv, input bit use3);
        for (int i = 0; i < n; i++) begin
            step();
            if (use3) begin
                check({tag, ".div"}, i, {1'b0, divclk3}, dv[4*i +: 4]);
                check({tag, ".tick"}, i, {1'b0, tick3}, tv[4*i +: 4]);
            end else begin
                check({tag, ".div"}, i, divclk, dv[4*i +: 4]);
                check({tag, ".tick"}, i, tick, tv[4*i +: 4]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
        en3 = '0; sync3 = 1'b0; wr_en3 = 1'b0; wr_ch3 = '0; wr_half3 = '0;

        // Reset defaults, then channel 0 at DEF_HALF = 4
        run("reset", 3, 64'd0, 64'd0, 1'b0);
        rst_n = 1'b1; en = 4'b0001;
        run("def", 16, lane(16'b0111_1000_0111_1000, 0),
                       lane(16'b0000_1000_0000_1000, 0), 1'b0);

        // Write H=2 in the middle of a low half
        run("mid", 1, 64'd0, 64'd0, 1'b0);
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd2;
        run("mid", 1, 64'd0, 64'd0, 1'b0);
        wr_en = 1'b0;
        run("mid", 6, lane(16'b10_0110, 0), lane(16'b10_0010, 0), 1'b0);

        // Write H=3 sampled on a toggle edge: one more half at H=2
        run("tog", 1, lane(16'b1, 0), 64'd0, 1'b0);
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd3;
        run("tog", 1, 64'd0, 64'd0, 1'b0);
        wr_en = 1'b0;
        run("tog", 8, lane(16'b1000_1110, 0), lane(16'b1000_0010, 0), 1'b0);

        // Divisor 0 on channel 1 behaves as 1
        en = 4'b0000; wr_en = 1'b1; wr_ch = 2'd1; wr_half = 32'd0;
        run("h0", 1, 64'd0, 64'd0, 1'b0);
        wr_en = 1'b0;
        run("h0", 1, 64'd0, 64'd0, 1'b0);
        en = 4'b0010;
        run("h0", 6, lane(16'b01_0101, 1), lane(16'b01_0101, 1), 1'b0);

        // Divisor 1 on channel 1: identical waveform
        en = 4'b0000; wr_en = 1'b1; wr_ch = 2'd1; wr_half = 32'd1;
        run("h1", 1, 64'd0, 64'd0, 1'b0);
        wr_en = 1'b0;
        run("h1", 1, 64'd0, 64'd0, 1'b0);
        en = 4'b0010;
        run("h1", 6, lane(16'b01_0101, 1), lane(16'b01_0101, 1), 1'b0);

        // Phase sync: ch0 H=3, ch2 H=6 started at unrelated times
        en = 4'b0000; wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd3;
        run("pre", 1, 64'd0, 64'd0, 1'b0);
        wr_ch = 2'd2; wr_half = 32'd6;
        run("pre", 1, 64'd0, 64'd0, 1'b0);
        wr_en = 1'b0;
        run("pre", 1, 64'd0, 64'd0, 1'b0);
        en = 4'b0001;
        repeat (5) step();
        en = 4'b0101;
        repeat (2) step();
        sync = 1'b1;
        run("sync0", 1, 64'd0, 64'd0, 1'b0);
        sync = 1'b0;
        run("sync", 12, lane(16'b0111_0001_1100, 0) | lane(16'b0111_1110_0000, 2),
                        lane(16'b0001_0000_0100, 0) | lane(16'b0000_0010_0000, 2), 1'b0);
        run("sync", 4, lane(16'b1100, 0), lane(16'b0100, 0), 1'b0);

        // Drop en[0] while high, then re-enable with shadow H=3
        en = 4'b0100;
        run("dis", 2, lane(16'b10, 2), lane(16'b10, 2), 1'b0);
        en = 4'b0101;
        run("reen", 3, lane(16'b100, 0) | lane(16'b111, 2), lane(16'b100, 0), 1'b0);

        // Reset while write, sync and enables are all active
        rst_n = 1'b0; sync = 1'b1; en = 4'b1111;
        wr_en = 1'b1; wr_ch = 2'd2; wr_half = 32'd9;
        run("rstact", 1, 64'd0, 64'd0, 1'b0);
        rst_n = 1'b1; sync = 1'b0; wr_en = 1'b0;
        run("post", 8, lane(16'b0111_1000, 0) | lane(16'b0111_1000, 1) |
                       lane(16'b0111_1000, 2) | lane(16'b0111_1000, 3),
                       lane(16'b0000_1000, 0) | lane(16'b0000_1000, 1) |
                       lane(16'b0000_1000, 2) | lane(16'b0000_1000, 3), 1'b0);

        // Out-of-range channel write on the three-channel instance
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_half3 = 32'd1;
        run("oor", 1, 64'd0, 64'd0, 1'b1);
        wr_en3 = 1'b0;
        run("oor", 1, 64'd0, 64'd0, 1'b1);
        en3 = 3'b111;
        run("oor", 4, lane(16'b0110, 0) | lane(16'b0110, 1) | lane(16'b0110, 2),
                      lane(16'b0010, 0) | lane(16'b0010, 1) | lane(16'b0010, 2), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multi_clkdiv
`default_nettype wire
